sdram_burst_master: RTL

- Avalon-MM burst master and traffic generator that drives the slave port of the team's SDRAM controller for hardware memory test.
- Writes NUM_BURSTS bursts of a pseudo-random pattern starting at a base word address.
- Reads the same region back, compares every beat against the regenerated pattern, and reports pass/fail, error count and the first failing address.
- Sits between a start/status register block and the SDRAM controller, in the hw_test Qsys system.

---
 rtl/sdram_burst_master.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/sdram_burst_master.sv
// sdram_burst_master: Avalon-MM burst traffic generator for SDRAM memory test.
// Writes NUM_BURSTS bursts of a pattern from base_addr, reads the region back,
// and reports pass/fail, a saturating error count and the first failing address.
// Optional build macro SDRAM_BURST_MASTER_ADDR_PATTERN_EN: pattern word becomes
// beat address[15:0] XOR seed and the LFSR is left out.
module sdram_burst_master #(
    parameter int          ADDR_W     = 22,
    parameter int          BURST      = 8,
    parameter int          NUM_BURSTS = 16,
    parameter logic [15:0] SEED       = 16'hACE1,
    parameter int          TIMEOUT    = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              m_read,
    output logic              m_write,
    output logic [ADDR_W-1:0] m_address,
    output logic [15:0]       m_writedata,
    output logic [8:0]        m_burstcount,
    output logic [1:0]        m_byteenable,
    input  logic              m_waitrequest,
    input  logic              m_readdatavalid,
    input  logic [15:0]       m_readdata
);

    localparam logic [15:0]      SEED_EFF   = (SEED == 16'h0000) ? 16'hACE1 : SEED;
    localparam logic [8:0]       LAST_BEAT  = 9'(BURST - 1);
    localparam logic [15:0]      LAST_BURST = 16'(NUM_BURSTS - 1);
    localparam int               TMO_W      = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT - 1);

    generate
        if (!(BURST == 1 || BURST == 2 || BURST == 4 || BURST == 8 || BURST == 256)) begin : g_bad_burst
            $error("sdram_burst_master: BURST must be 1, 2, 4, 8 or 256");
        end
        if (NUM_BURSTS < 1 || NUM_BURSTS > 65535) begin : g_bad_num_bursts
            $error("sdram_burst_master: NUM_BURSTS must be 1..65535");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        WR_BEAT,
        WR_GAP,
        RD_REQ,
        RD_DATA,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] base_q;
    logic [8:0]        beat_idx;
    logic [15:0]       burst_idx;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [15:0]       pattern;

    logic start_take;
    logic acc_wr;
    logic acc_rd;
    logic rd_beat;
    logic tmo_hit;
    logic last_beat;
    logic last_burst;
    logic tmo_expired;
    logic counting;
    logic mismatch;

    assign last_beat    = (beat_idx == LAST_BEAT);
    assign last_burst   = (burst_idx == LAST_BURST);
    assign tmo_expired  = (tmo_cnt == TMO_LAST);
    assign counting     = (state == WR_BEAT) || (state == RD_REQ) || (state == RD_DATA);
    assign busy         = counting || (state == WR_GAP);
    assign done         = (state == DONE);
    assign pass         = done && (err_count == 16'h0000) && !timeout;
    assign m_address    = cur_addr;
    assign m_writedata  = (state == WR_BEAT) ? pattern : 16'h0000;
    assign m_burstcount = 9'(BURST);
    assign m_byteenable = 2'b11;
    assign mismatch     = (m_readdata != pattern);

    // State register; reset aborts any run and drops the bus immediately.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus bus strobes and the per-cycle event flags used by the datapath.
    always_comb begin
        state_next = state;
        m_write    = 1'b0;
        m_read     = 1'b0;
        start_take = 1'b0;
        acc_wr     = 1'b0;
        acc_rd     = 1'b0;
        rd_beat    = 1'b0;
        tmo_hit    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    start_take = 1'b1;
                    state_next = WR_BEAT;
                end
            end
            WR_BEAT: begin
                m_write = 1'b1;
                if (!m_waitrequest) begin
                    acc_wr = 1'b1;
                    if (last_beat) begin
                        state_next = WR_GAP;
                    end
                end else if (tmo_expired) begin
                    tmo_hit    = 1'b1;
                    state_next = DONE;
                end
            end
            WR_GAP: begin
                state_next = last_burst ? RD_REQ : WR_BEAT;
            end
            RD_REQ: begin
                m_read = 1'b1;
                if (!m_waitrequest) begin
                    acc_rd     = 1'b1;
                    state_next = RD_DATA;
                end else if (tmo_expired) begin
                    tmo_hit    = 1'b1;
                    state_next = DONE;
                end
            end
            RD_DATA: begin
                if (m_readdatavalid) begin
                    rd_beat = 1'b1;
                    if (last_beat) begin
                        state_next = last_burst ? DONE : RD_REQ;
                    end
                end else if (tmo_expired) begin
                    tmo_hit    = 1'b1;
                    state_next = DONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Address walk, beat/burst counters, watchdog and error bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_addr       <= '0;
            base_q         <= '0;
            beat_idx       <= '0;
            burst_idx      <= '0;
            tmo_cnt        <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
            timeout        <= 1'b0;
        end else if (start_take) begin
            cur_addr       <= base_addr;
            base_q         <= base_addr;
            beat_idx       <= '0;
            burst_idx      <= '0;
            tmo_cnt        <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
            timeout        <= 1'b0;
        end else begin
            if (acc_wr || acc_rd || rd_beat) begin
                tmo_cnt <= '0;
            end else if (counting) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
            if (tmo_hit) begin
                timeout <= 1'b1;
            end
            if (acc_wr || rd_beat) begin
                cur_addr <= cur_addr + ADDR_W'(1);
                beat_idx <= last_beat ? 9'd0 : beat_idx + 9'd1;
            end
            if (state == WR_GAP) begin
                if (last_burst) begin
                    burst_idx <= '0;
                    cur_addr  <= base_q;
                end else begin
                    burst_idx <= burst_idx + 16'd1;
                end
            end
            if (rd_beat && last_beat) begin
                burst_idx <= burst_idx + 16'd1;
            end
            if (rd_beat && mismatch) begin
                if (err_count != 16'hFFFF) begin
                    err_count <= err_count + 16'd1;
                end
                if (err_count == 16'h0000) begin
                    first_err_addr <= cur_addr;
                end
            end
        end
    end

`ifdef SDRAM_BURST_MASTER_ADDR_PATTERN_EN
    assign pattern = 16'(cur_addr) ^ SEED_EFF;
`else
    logic [15:0] lfsr;

    assign pattern = lfsr;

    // Galois LFSR x^16+x^14+x^13+x^11+1; reseeded per pass, stepped only on real beats.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= SEED_EFF;
        end else if (start_take || (state == WR_GAP && last_burst)) begin
            lfsr <= SEED_EFF;
        end else if (acc_wr || rd_beat) begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end
`endif

endmodule
